// File: rtl/npc_pkg.sv
// Shared types for the fetch next-PC generator:
// BTB entry layout and 2-bit direction counter.
package npc_pkg;

  localparam int NPC_XLEN_MAX = 32;
  localparam int NPC_TAG_W    = NPC_XLEN_MAX - 3;
  localparam int NPC_TGT_W    = NPC_XLEN_MAX - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic                 valid;
    logic [NPC_TAG_W-1:0] tag;
    logic [NPC_TGT_W-1:0] target;
    ctr_e                 ctr;
  } btb_entry_t;

  function automatic ctr_e sat_ctr_next(
    input ctr_e c,
    input logic taken
  );
    ctr_e n;
    case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = SNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/npc_predict_gen_if.sv
// Fetch/ID/EX signals seen by the next-PC generator.
// slave = the generator, master = surrounding pipeline.
interface npc_predict_gen_if #(
  parameter int XLEN = 32
);
  logic            stall_f;
  logic            id_jal_valid;
  logic [XLEN-1:0] id_jal_target;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic [XLEN-1:0] pc_f;
  logic            pred_taken_f;
  logic [XLEN-1:0] pred_target_f;
  logic            flush_fd;
  logic            flush_de;
  logic [31:0]     mispred_cnt;

  modport master (
    output stall_f, id_jal_valid, id_jal_target,
    output ex_valid, ex_pc, ex_taken, ex_target,
    output ex_pred_taken, ex_pred_target,
    input  pc_f, pred_taken_f, pred_target_f,
    input  flush_fd, flush_de, mispred_cnt
  );

  modport slave (
    input  stall_f, id_jal_valid, id_jal_target,
    input  ex_valid, ex_pc, ex_taken, ex_target,
    input  ex_pred_taken, ex_pred_target,
    output pc_f, pred_taken_f, pred_target_f,
    output flush_fd, flush_de, mispred_cnt
  );
endinterface

// File: rtl/btb_table.sv
// Direct-mapped BTB: combinational lookup, posedge update.
// Ports carry word addresses (pc[XLEN-1:2]).
module btb_table
  import npc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-3:0] lk_pcw,
  output logic            lk_taken,
  output logic [XLEN-1:0] lk_target,
  input  logic            up_en,
  input  logic [XLEN-3:0] up_pcw,
  input  logic            up_taken,
  input  logic [XLEN-3:0] up_target
);

  localparam int IDX = $clog2(BTB_DEPTH);

  logic [BTB_DEPTH-1:0] valid_q;
  btb_entry_t           mem [BTB_DEPTH];

  logic [IDX-1:0]       lk_idx;
  logic [IDX-1:0]       up_idx;
  logic [NPC_TAG_W-1:0] lk_tag;
  logic [NPC_TAG_W-1:0] up_tag;
  logic                 lk_hit;
  logic                 up_hit;

  assign lk_idx = lk_pcw[IDX-1:0];
  assign up_idx = up_pcw[IDX-1:0];
  assign lk_tag = NPC_TAG_W'(lk_pcw[XLEN-3:IDX]);
  assign up_tag = NPC_TAG_W'(up_pcw[XLEN-3:IDX]);

  // valid_q gates the unreset array, so X contents never leak out
  assign lk_hit = valid_q[lk_idx]
                & mem[lk_idx].valid
                & (mem[lk_idx].tag == lk_tag);
  assign up_hit = valid_q[up_idx]
                & mem[up_idx].valid
                & (mem[up_idx].tag == up_tag);

  assign lk_taken  = lk_hit & mem[lk_idx].ctr[1];
  assign lk_target = lk_taken
                   ? {mem[lk_idx].target[XLEN-3:0], 2'b00}
                   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (up_en & (up_hit | up_taken)) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (up_en) begin
      if (up_hit) begin
        mem[up_idx].ctr <= sat_ctr_next(mem[up_idx].ctr, up_taken);
        if (up_taken) begin
          mem[up_idx].target <= NPC_TGT_W'(up_target);
        end
      end else if (up_taken) begin
        mem[up_idx] <= '{
          valid:  1'b1,
          tag:    up_tag,
          target: NPC_TGT_W'(up_target),
          ctr:    WT
        };
      end
    end
  end

endmodule

// File: rtl/npc_predict_gen.sv
// Fetch PC register, next-PC priority mux, EX mispredict
// detection, pipeline flush requests and mispredict counter.
module npc_predict_gen
  import npc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BTB_DEPTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  npc_predict_gen_if.slave  io
);

  localparam logic [XLEN-1:0] STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] next_pc;
  logic [31:0]     cnt_q;
  logic            mispredict;
  logic            jal_go;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  assign mispredict = io.ex_valid
    & ((io.ex_taken != io.ex_pred_taken)
     | (io.ex_taken & (io.ex_target != io.ex_pred_target)));

  assign jal_go = io.id_jal_valid & ~io.stall_f;

  btb_table #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .lk_pcw    (pc_q[XLEN-1:2]),
    .lk_taken  (pred_taken),
    .lk_target (pred_target),
    .up_en     (io.ex_valid),
    .up_pcw    (io.ex_pc[XLEN-1:2]),
    .up_taken  (io.ex_taken),
    .up_target (io.ex_target[XLEN-1:2])
  );

  // a resolved mispredict outranks a stall: the stalled slot is wrong-path
  always_comb begin
    next_pc = pc_q + STEP;
    if (mispredict) begin
      next_pc = io.ex_taken ? io.ex_target : io.ex_pc + STEP;
    end else if (jal_go) begin
      next_pc = io.id_jal_target;
    end else if (io.stall_f) begin
      next_pc = pc_q;
    end else if (pred_taken) begin
      next_pc = pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC & ALIGN;
      cnt_q <= '0;
    end else begin
      pc_q <= next_pc & ALIGN;
      if (mispredict && cnt_q != '1) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign io.pc_f          = pc_q;
  assign io.pred_taken_f  = pred_taken;
  assign io.pred_target_f = pred_target;
  assign io.flush_de      = rst_n & mispredict;
  assign io.flush_fd      = rst_n & (mispredict | jal_go);
  assign io.mispred_cnt   = cnt_q;

endmodule
